// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue
//   Instruction prefetch stage between instruction memory and the ID stage.
//   It fetches sequential PCs ahead of decode and buffers up to DEPTH
//   instructions. One instruction per cycle is presented to ID. A taken
//   branch flushes the queue and redirects fetch.
//
// Ports
//   clk                pipeline clock
//   rst                asynchronous reset, active-low
//   imem_req/addr      fetch request and address (address = fetch_pc)
//   imem_data/valid    memory response, valid one cycle after imem_req
//   pipeline_stall_n   0 = ID stalled; the instruction outputs hold
//   branch_taken       ID resolved a taken branch this cycle
//   branch_offset_imm  signed 6-bit branch offset, relative to instr_pc + 1
//   instruction/instr_pc/instr_valid  registered outputs to ID
//   queue_count        number of occupied queue entries
//
// Build option
//   IFQ_BYPASS_EN  When this macro is defined, a response that arrives while
//                  the queue is empty goes straight to the outputs. This
//                  cuts one cycle from the fetch-to-ID latency.
module if_prefetch_queue #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   imem_valid,
  input  logic                   pipeline_stall_n,
  input  logic                   branch_taken,
  input  logic [5:0]             branch_offset_imm,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  output logic [$clog2(DEPTH):0] queue_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic                   inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]    tag_q, tag_d;
  logic                   stale_ok_q, stale_ok_d;
  logic [AW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [INSTR_WIDTH-1:0] instruction_q, instruction_d;
  logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;
  logic                   instr_valid_q, instr_valid_d;

  logic [INSTR_WIDTH-1:0] mem_data_q [DEPTH];
  logic [PC_WIDTH-1:0]    mem_pc_q   [DEPTH];

  logic                   rsp_ok, push, pop, bypass;
  logic [PC_WIDTH-1:0]    offset_sext;

  // Outstanding requests are counted against capacity. Because of this,
  // a response always has a free slot.
  assign imem_req  = rst && !branch_taken &&
                     ((count_q + CW'(inflight_q)) < CW'(DEPTH));
  assign imem_addr = fetch_pc_q;

  // A response that arrives during the branch cycle belongs to the old path.
  assign rsp_ok = imem_valid && inflight_q && !branch_taken;

`ifdef IFQ_BYPASS_EN
  assign bypass = rsp_ok && pipeline_stall_n && (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push        = rsp_ok && !bypass;
  assign pop         = pipeline_stall_n && !branch_taken && (count_q != '0);
  assign offset_sext = {{(PC_WIDTH-6){branch_offset_imm[5]}}, branch_offset_imm};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = imem_req;
    tag_d         = imem_req ? fetch_pc_q : tag_q;
    stale_ok_d    = branch_taken;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    instruction_d = instruction_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    if (branch_taken) begin
      fetch_pc_d = instr_pc_q + PC_WIDTH'(1) + offset_sext;
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
    end

    if (branch_taken) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    if (branch_taken) begin
      instruction_d = '0;
      instr_valid_d = 1'b0;
    end else if (pipeline_stall_n) begin
      if (pop) begin
        instruction_d = mem_data_q[head_q];
        instr_pc_d    = mem_pc_q[head_q];
        instr_valid_d = 1'b1;
      end else if (bypass) begin
        instruction_d = imem_data;
        instr_pc_d    = tag_q;
        instr_valid_d = 1'b1;
      end else begin
        // Bubble: instr_pc keeps the last real PC so that a branch stays relative to it.
        instruction_d = '0;
        instr_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      tag_q         <= '0;
      stale_ok_q    <= 1'b1;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      instruction_q <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      tag_q         <= tag_d;
      stale_ok_q    <= stale_ok_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      instruction_q <= instruction_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Queue storage. The storage is not reset; it is only read below count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[tail_q] <= imem_data;
      mem_pc_q[tail_q]   <= tag_q;
    end
  end

  assign instruction = instruction_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign queue_count = count_q;

  // A response with nothing outstanding is tolerated only in the cycle
  // after reset or after a branch (a stale or cancelled return).
  assert property (@(posedge clk) disable iff (!rst)
                   imem_valid |-> (inflight_q || stale_ok_q));

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        pipeline_stall_n;
  logic        branch_taken;
  logic [5:0]  branch_offset_imm;
  logic [15:0] instruction;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic [2:0]  queue_count;

  logic        stale;
  logic        prev_req;
  bit          sb_en;
  int          checks;
  int          errors;

  typedef struct packed {
    logic [15:0] ins;
    logic [7:0]  pc;
  } exp_t;
  exp_t sb[$];

  if_prefetch_queue #(.PC_WIDTH(8), .INSTR_WIDTH(16), .DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_data         (imem_data),
    .imem_valid        (imem_valid),
    .pipeline_stall_n  (pipeline_stall_n),
    .branch_taken      (branch_taken),
    .branch_offset_imm (branch_offset_imm),
    .instruction       (instruction),
    .instr_pc          (instr_pc),
    .instr_valid       (instr_valid),
    .queue_count       (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: mem[a] = 16'h1000 + a, one-cycle response.
  // The stale flag injects a response that no request asked for.
  always @(posedge clk) begin
    imem_valid <= (imem_req && rst) || stale;
    imem_data  <= stale ? 16'hDEAD : (16'h1000 + {8'h00, imem_addr});
    prev_req   <= imem_req;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL timeout_%s: condition not reached within cycle budget", nm);
  endtask

  task automatic push_exp(input logic [7:0] pc);
    exp_t e;
    e.ins = 16'h1000 + {8'h00, pc};
    e.pc  = pc;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [7:0] pc, input int lim, input string nm);
    bit found;
    found = 0;
    for (int i = 0; i < lim && !found; i++) begin
      if (instr_valid && instr_pc == pc) found = 1;
      else step();
    end
    if (!found) timeout(nm);
  endtask

  // An instruction is consumed by ID when it is valid and ID is not stalled.
  always @(negedge clk) begin
    if (rst && sb_en && instr_valid && pipeline_stall_n) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got pc %h ins %h, expected no instruction", instr_pc, instruction);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (instruction !== e.ins || instr_pc !== e.pc) begin
          errors++;
          $display("FAIL sb_order: got pc %h ins %h, expected pc %h ins %h",
                   instr_pc, instruction, e.pc, e.ins);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1'b0; pipeline_stall_n = 1'b1; branch_taken = 1'b0;
    branch_offset_imm = 6'h00; stale = 1'b0; sb_en = 0;
    checks = 0; errors = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr", instruction, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_count", queue_count, 0);
    chk("rst_req", imem_req, 0);

    // Sequential fetch after reset release (cycle 0 starts here).
    rst = 1'b1;
    for (int p = 0; p <= 5; p++) push_exp(p[7:0]);
    sb_en = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("seq_addr", imem_addr, c);
      chk("seq_req", imem_req, 1);
      chk("seq_valid", instr_valid, (c >= LAT) ? 1 : 0);
      if (c == LAT) begin
        chk("first_instr", instruction, 32'h1000);
        chk("first_pc", instr_pc, 0);
      end
      step();
    end

    // Stall for 10 cycles starting in cycle 4.
    pipeline_stall_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_instr", instruction, 16'h1000 + 16'(4 - LAT));
      chk("stall_pc", instr_pc, 4 - LAT);
      chk("stall_valid", instr_valid, 1);
      if (i == 9) begin
        chk("stall_count", queue_count, 4);
        chk("stall_req", imem_req, 0);
      end
      step();
    end
    pipeline_stall_n = 1'b1;

    // Buffered instructions drain with no gap until PC 5 is presented.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid && instr_pc == 8'h05) found = 1;
      else begin
        @(negedge clk);
        chk("no_gap", instr_valid, 1);
        step();
      end
    end
    if (!found) timeout("pc5");

    // Branch at PC 5 with offset -2: the target is 4.
    branch_taken = 1'b1; branch_offset_imm = 6'h3E;
    push_exp(8'h04);
    @(negedge clk);
    chk("br_req", imem_req, 0);
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("br_valid", instr_valid, 0);
    chk("br_addr", imem_addr, 8'h04);
    chk("br_newreq", imem_req, 1);
    chk("br_count", queue_count, 0);
    step();

    // At PC 4, branch with offset -7: the target is 8'hFE. Then check the fetch wrap.
    wait_pc(8'h04, 10, "pc4");
    branch_taken = 1'b1; branch_offset_imm = 6'h39;
    push_exp(8'hFE); push_exp(8'hFF); push_exp(8'h00);
    step();
    branch_taken = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wrap_addr", imem_addr, 8'(8'hFE + k));
      chk("wrap_req", imem_req, 1);
      step();
    end
    wait_pc(8'h01, 10, "pc01");
    pipeline_stall_n = 1'b0;

    // Reset mid-stream when queue_count=3 and a request is in flight.
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (queue_count == 3 && prev_req) found = 1;
      else step();
    end
    if (!found) timeout("count3");
    sb_en = 0;
    chk("sb_drain1", sb.size(), 0);
    #1 rst = 1'b0;
    #1;
    chk("mrst_instr", instruction, 0);
    chk("mrst_pc", instr_pc, 0);
    chk("mrst_valid", instr_valid, 0);
    chk("mrst_count", queue_count, 0);
    chk("mrst_req", imem_req, 0);
    chk("mrst_addr", imem_addr, 0);
    step();
    pipeline_stall_n = 1'b1;
    stale = 1'b1;
    step();
    stale = 1'b0;
    rst = 1'b1;
    push_exp(8'h00); push_exp(8'h01); push_exp(8'h02);
    sb_en = 1;
    @(negedge clk);
    chk("rel_addr", imem_addr, 0);
    chk("rel_req", imem_req, 1);
    chk("rel_valid", instr_valid, 0);
    step();

    // Stall at PC 3 until the queue is full, then branch while still stalled.
    wait_pc(8'h03, 12, "pc3");
    pipeline_stall_n = 1'b0;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (queue_count == 4) found = 1;
      else step();
    end
    if (!found) timeout("full");
    chk("full_req", imem_req, 0);
    branch_taken = 1'b1; branch_offset_imm = 6'h0A;
    push_exp(8'h0E); push_exp(8'h0F); push_exp(8'h10);
    @(negedge clk);
    chk("sbr_req", imem_req, 0);
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("sbr_count", queue_count, 0);
    chk("sbr_valid", instr_valid, 0);
    chk("sbr_newreq", imem_req, 1);
    chk("sbr_addr", imem_addr, 8'h0E);
    step();
    pipeline_stall_n = 1'b1;

    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (sb.size() == 0) found = 1;
      else step();
    end
    sb_en = 0;
    if (!found) timeout("drain");

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
